branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32 pipeline.
- Replaces the fixed "BNE always taken" guess made in ID.
- IF reads it combinationally with the current pc. EX writes the resolved outcome back.
- Contents: direct-mapped table of tagged entries, each with a saturating counter and a target. Optional global-history (gshare) indexing.

Parameters:
IDX_BITS, 6, log2 of table entries (64 entries)
TAG_BITS, 8, tag width taken from pc above the index bits
CNT_BITS, 2, saturating-counter width
MODE, 0, 0 = bimodal index, 1 = gshare index (pc index XOR ghr)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
ce  in  1  clock enable; no state changes while low
lk_pc  in  32  IF-stage pc to predict
lk_valid  in  1  IF is fetching lk_pc this cycle
pred_hit  out  1  tag match on a valid entry
pred_taken  out  1  predict taken (pred_hit & counter MSB)
pred_target  out  32  stored target; 0 when !pred_hit
pred_ghr  out  IDX_BITS  ghr snapshot the pipeline carries with the branch
upd_valid  in  1  EX resolved a conditional branch this cycle
upd_pc  in  32  pc of the resolved branch
upd_ghr  in  IDX_BITS  ghr snapshot carried from lookup
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target (pc+imm)
upd_mispredict  in  1  predicted direction/target was wrong
perf_lookups  out  32  lookups with lk_valid
perf_branches  out  32  resolved branches
perf_mispredicts  out  32  mispredicts

Behaviour:
- Reset (asynchronous, any time, including mid-update):
  - All entry valid bits cleared; ghr = 0; perf counters = 0.
  - pred_hit = 0, pred_taken = 0, pred_target = 0, pred_ghr = 0.
  - Counter, tag and target arrays need no reset.
- Index:
  - pcidx = pc[IDX_BITS+1:2].
  - MODE 0: index = pcidx.
  - MODE 1: lookup index = pcidx ^ ghr; update index = pcidx ^ upd_ghr.
- Tag = pc[TAG_BITS+IDX_BITS+1 : IDX_BITS+2].
- Lookup: purely combinational from registered state, 0-cycle latency.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. No bypass.
- Update, on posedge when ce & upd_valid:
  - Hit: counter += 1 if upd_taken (saturates at 2^CNT_BITS-1), else -= 1 (saturates at 0). If upd_taken, target <= upd_target.
  - Miss and upd_taken: allocate. valid=1, tag written, target=upd_target, counter = weakly taken (MSB=1, other bits 0). Any aliasing entry is overwritten.
  - Miss and not taken: no change.
- ghr (MODE 1 only; held at 0 in MODE 0), on posedge when ce:
  - upd_valid & upd_mispredict: ghr <= {upd_ghr[IDX_BITS-2:0], upd_taken} (repair).
  - Else lk_valid & pred_hit: ghr <= {ghr[IDX_BITS-2:0], pred_taken} (speculative shift).
  - Repair has priority over a same-cycle speculative shift.
- pred_ghr = ghr current value, combinational.
- ce low: no array, ghr or counter change. Outputs still track lk_pc.

Optional Feature:
- Macro: BRANCH_PREDICTOR_PERF_EN.
- Defined: the three perf counters increment on posedge when ce, each on its event:
  - perf_lookups: lk_valid.
  - perf_branches: upd_valid.
  - perf_mispredicts: upd_valid & upd_mispredict.
  - Counters wrap modulo 2^32.
- Not defined: perf outputs tied to 0 and no counter flops are built.

Decomposition:
- Shared package bp_pkg holds:
  - MODE encodings BP_MODE_BIMODAL=0 and BP_MODE_GSHARE=1.
  - A function for the weakly-taken counter init value.
  - Index/tag slice helper functions.
- One sub-module, bp_sat_counter: parametrised CNT_BITS, combinational next-value from (cur, taken). Instantiated on the update path.

Test Plan:
- Reset, then lk_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0. Assert rst mid-update -> entry 0x40 still misses after release.
- MODE 0: update pc=0x40, taken=1, target=0x20. Next cycle lk_pc=0x40 -> hit=1, taken=1, target=0x20, counter=2'b10.
- Three more taken updates -> counter saturates at 3. Then two not-taken -> counter=1, pred_taken=0, hit stays 1, target stays 0x20.
- Alias: lk_pc=0x140 (same index as 0x40, different tag) -> hit=0. Taken update at 0x140, target 0x80 -> 0x40 now misses, 0x140 hits with 0x80.
- Same cycle: update 0x40 not-taken while lk_pc=0x40 at counter=2 -> that cycle pred_taken=1. Next cycle pred_taken=0.
- MODE 1, ghr=6'b110000, lk hit, plus same-cycle mispredict with upd_ghr=6'b000101, upd_taken=1 -> ghr=6'b001011. With ce=0 the same stimulus leaves ghr unchanged. Perf macro on -> perf_mispredicts increments by exactly 1.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: mode encodings and the
// pc slicing / counter-init helpers used by both lookup and update paths.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Weakly-taken init value: MSB set, every lower bit clear.
    function automatic logic [31:0] bpWeakTaken(input int cntBits);
        return 32'd1 << (cntBits - 1);
    endfunction

    // Table index straight from the pc (word aligned, so bits [1:0] are skipped).
    function automatic logic [31:0] bpPcIndex(input logic [31:0] pc, input int idxBits);
        return (pc >> 2) & ((32'd1 << idxBits) - 32'd1);
    endfunction

    // Tag bits sit directly above the index bits.
    function automatic logic [31:0] bpPcTag(input logic [31:0] pc, input int idxBits,
                                            input int tagBits);
        return (pc >> (idxBits + 2)) & ((32'd1 << tagBits) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline (IF lookup, EX update) and the branch predictor.
// The pipeline owns the master side, the predictor the slave side.
interface branch_predictor_if #(
    parameter int IDX_BITS = 6
);
    logic                ce;
    logic                lk_valid;
    logic [31:0]         lk_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [IDX_BITS-1:0] pred_ghr;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic [IDX_BITS-1:0] upd_ghr;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                upd_mispredict;
    logic [31:0]         perf_lookups;
    logic [31:0]         perf_branches;
    logic [31:0]         perf_mispredicts;

    modport master (
        output ce, lk_valid, lk_pc,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
        input  pred_hit, pred_taken, pred_target, pred_ghr,
        input  perf_lookups, perf_branches, perf_mispredicts
    );

    modport slave (
        input  ce, lk_valid, lk_pc,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
        output pred_hit, pred_taken, pred_target, pred_ghr,
        output perf_lookups, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for one saturating direction counter.
module bp_sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] i_cur,
    input  logic                i_taken,
    output logic [CNT_BITS-1:0] o_next
);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // Step toward the observed direction, sticking at either end.
    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != CNT_MAX) o_next = i_cur + CNT_BITS'(1);
        end else if (i_cur != '0) begin
            o_next = i_cur - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor with saturating counters and stored
// targets, optional gshare indexing (MODE=1). Lookup is combinational from
// registered state; EX writes resolved outcomes back on the clock edge.
// Optional macro BRANCH_PREDICTOR_PERF_EN builds the three perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 2,
    parameter int MODE     = BP_MODE_BIMODAL
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(bpWeakTaken(CNT_BITS));

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
    logic [IDX_BITS-1:0] r_ghr;

    logic [IDX_BITS-1:0] w_lkPcIdx;
    logic [IDX_BITS-1:0] w_lkIdx;
    logic [TAG_BITS-1:0] w_lkTag;
    logic                w_lkHit;
    logic                w_lkTaken;
    logic [IDX_BITS-1:0] w_updPcIdx;
    logic [IDX_BITS-1:0] w_updIdx;
    logic [TAG_BITS-1:0] w_updTag;
    logic                w_updHit;
    logic                w_updEn;
    logic [CNT_BITS-1:0] w_cntNext;

    assign w_lkPcIdx  = IDX_BITS'(bpPcIndex(bus.lk_pc, IDX_BITS));
    assign w_lkIdx    = (MODE == BP_MODE_GSHARE) ? (w_lkPcIdx ^ r_ghr) : w_lkPcIdx;
    assign w_lkTag    = TAG_BITS'(bpPcTag(bus.lk_pc, IDX_BITS, TAG_BITS));
    assign w_lkHit    = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
    assign w_lkTaken  = w_lkHit && r_cnt[w_lkIdx][CNT_BITS-1];

    assign w_updPcIdx = IDX_BITS'(bpPcIndex(bus.upd_pc, IDX_BITS));
    assign w_updIdx   = (MODE == BP_MODE_GSHARE) ? (w_updPcIdx ^ bus.upd_ghr) : w_updPcIdx;
    assign w_updTag   = TAG_BITS'(bpPcTag(bus.upd_pc, IDX_BITS, TAG_BITS));
    assign w_updHit   = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_updEn    = bus.ce && bus.upd_valid;

    assign bus.pred_hit    = w_lkHit;
    assign bus.pred_taken  = w_lkTaken;
    assign bus.pred_target = w_lkHit ? r_target[w_lkIdx] : 32'd0;
    assign bus.pred_ghr    = r_ghr;

    bp_sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_satCounter (
        .i_cur   (r_cnt[w_updIdx]),
        .i_taken (bus.upd_taken),
        .o_next  (w_cntNext)
    );

    // Valid bits are the only array state that needs reset; allocation sets them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_updEn && !w_updHit && bus.upd_taken) begin
            r_valid[w_updIdx] <= 1'b1;
        end
    end

    // Counter/tag/target writes: train on a hit, allocate weakly-taken on a taken miss.
    always_ff @(posedge clk) begin
        if (w_updEn) begin
            if (w_updHit) begin
                r_cnt[w_updIdx] <= w_cntNext;
                if (bus.upd_taken) r_target[w_updIdx] <= bus.upd_target;
            end else if (bus.upd_taken) begin
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= bus.upd_target;
                r_cnt[w_updIdx]    <= CNT_WEAK;
            end
        end
    end

    generate
        if (MODE == BP_MODE_GSHARE) begin : g_gshare
            // History: a mispredict repair wins over the speculative shift of a hit lookup.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (bus.ce) begin
                    if (bus.upd_valid && bus.upd_mispredict) begin
                        r_ghr <= {bus.upd_ghr[IDX_BITS-2:0], bus.upd_taken};
                    end else if (bus.lk_valid && w_lkHit) begin
                        r_ghr <= {r_ghr[IDX_BITS-2:0], w_lkTaken};
                    end
                end
            end
        end else begin : g_bimodal
            assign r_ghr = '0;
        end
    endgenerate

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] r_perfLookups;
    logic [31:0] r_perfBranches;
    logic [31:0] r_perfMispredicts;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfLookups     <= '0;
            r_perfBranches    <= '0;
            r_perfMispredicts <= '0;
        end else if (bus.ce) begin
            if (bus.lk_valid) r_perfLookups <= r_perfLookups + 32'd1;
            if (bus.upd_valid) r_perfBranches <= r_perfBranches + 32'd1;
            if (bus.upd_valid && bus.upd_mispredict) r_perfMispredicts <= r_perfMispredicts + 32'd1;
        end
    end

    assign bus.perf_lookups     = r_perfLookups;
    assign bus.perf_branches    = r_perfBranches;
    assign bus.perf_mispredicts = r_perfMispredicts;
`else
    assign bus.perf_lookups     = 32'd0;
    assign bus.perf_branches    = 32'd0;
    assign bus.perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: one bimodal and one gshare instance driven with
// identical stimulus and compared against a table/array reference model.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_if #(.IDX_BITS(6)) bus0 ();
    branch_predictor_if #(.IDX_BITS(6)) bus1 ();

    branch_predictor #(.IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(2), .MODE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    branch_predictor #(.IDX_BITS(6), .TAG_BITS(8), .CNT_BITS(2), .MODE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    // Current stimulus, applied to both instances.
    bit          sCe;
    bit          sLkValid;
    logic [31:0] sLkPc;
    bit          sUpdValid;
    logic [31:0] sUpdPc;
    logic [5:0]  sUpdGhr;
    bit          sUpdTaken;
    logic [31:0] sUpdTarget;
    bit          sUpdMis;

    // Reference model: per-mode arrays of entries and a history value.
    bit          mValid [2][64];
    int          mTag   [2][64];
    logic [31:0] mTgt   [2][64];
    int          mCnt   [2][64];
    int          mGhr   [2];
    int unsigned mPerf  [3];

    typedef struct {
        bit          ce;
        bit          lkValid;
        logic [31:0] lkPc;
        bit          updValid;
        logic [31:0] updPc;
        bit          updTaken;
        logic [31:0] updTarget;
        bit          updMis;
        bit          expHit;
        bit          expTaken;
        logic [31:0] expTarget;
    } vec_t;

    vec_t vecs [16];

    function automatic int mdlIdx(input int m, input logic [31:0] pc, input int ghr);
        int base = int'((pc >> 2) % 64);
        return (m == 1) ? (base ^ ghr) : base;
    endfunction

    function automatic int mdlTag(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic void mdlLookup(input int m, input logic [31:0] pc, output bit hit,
                                      output bit taken, output logic [31:0] tgt);
        int i = mdlIdx(m, pc, mGhr[m]);
        hit   = mValid[m][i] && (mTag[m][i] == mdlTag(pc));
        taken = hit && (mCnt[m][i] >= 2);
        tgt   = hit ? mTgt[m][i] : 32'd0;
    endfunction

    function automatic void mdlReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) mValid[m][i] = 1'b0;
            mGhr[m] = 0;
        end
        for (int k = 0; k < 3; k++) mPerf[k] = 0;
    endfunction

    function automatic void mdlClock();
        bit          lkHit;
        bit          lkTaken;
        logic [31:0] lkTgt;
        int          i;
        if (!sCe) return;
        for (int m = 0; m < 2; m++) begin
            mdlLookup(m, sLkPc, lkHit, lkTaken, lkTgt);
            i = mdlIdx(m, sUpdPc, int'(sUpdGhr));
            if (sUpdValid) begin
                if (mValid[m][i] && mTag[m][i] == mdlTag(sUpdPc)) begin
                    if (sUpdTaken) begin
                        mCnt[m][i] = (mCnt[m][i] < 3) ? mCnt[m][i] + 1 : 3;
                        mTgt[m][i] = sUpdTarget;
                    end else begin
                        mCnt[m][i] = (mCnt[m][i] > 0) ? mCnt[m][i] - 1 : 0;
                    end
                end else if (sUpdTaken) begin
                    mValid[m][i] = 1'b1;
                    mTag[m][i]   = mdlTag(sUpdPc);
                    mTgt[m][i]   = sUpdTarget;
                    mCnt[m][i]   = 2;
                end
            end
            if (m == 1) begin
                if (sUpdValid && sUpdMis) mGhr[m] = (int'(sUpdGhr) * 2 + int'(sUpdTaken)) % 64;
                else if (sLkValid && lkHit) mGhr[m] = (mGhr[m] * 2 + int'(lkTaken)) % 64;
            end
        end
        if (sLkValid) mPerf[0]++;
        if (sUpdValid) mPerf[1]++;
        if (sUpdValid && sUpdMis) mPerf[2]++;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        sCe = 1'b1; sLkValid = 1'b0; sLkPc = 32'd0;
        sUpdValid = 1'b0; sUpdPc = 32'd0; sUpdGhr = 6'd0;
        sUpdTaken = 1'b0; sUpdTarget = 32'd0; sUpdMis = 1'b0;
    endtask

    task automatic driveBus();
        bus0.ce = sCe; bus0.lk_valid = sLkValid; bus0.lk_pc = sLkPc;
        bus0.upd_valid = sUpdValid; bus0.upd_pc = sUpdPc; bus0.upd_ghr = sUpdGhr;
        bus0.upd_taken = sUpdTaken; bus0.upd_target = sUpdTarget; bus0.upd_mispredict = sUpdMis;
        bus1.ce = sCe; bus1.lk_valid = sLkValid; bus1.lk_pc = sLkPc;
        bus1.upd_valid = sUpdValid; bus1.upd_pc = sUpdPc; bus1.upd_ghr = sUpdGhr;
        bus1.upd_taken = sUpdTaken; bus1.upd_target = sUpdTarget; bus1.upd_mispredict = sUpdMis;
    endtask

    // Compare every output of both instances against the model's current state.
    task automatic compareAll();
        bit          eHit;
        bit          eTaken;
        logic [31:0] eTgt;
        logic [31:0] ePerf [3];
        for (int m = 0; m < 2; m++) begin
            mdlLookup(m, sLkPc, eHit, eTaken, eTgt);
`ifdef BRANCH_PREDICTOR_PERF_EN
            for (int k = 0; k < 3; k++) ePerf[k] = mPerf[k];
`else
            for (int k = 0; k < 3; k++) ePerf[k] = 32'd0;
`endif
            if (m == 0) begin
                checkOutput("m0_hit", bus0.pred_hit, eHit);
                checkOutput("m0_taken", bus0.pred_taken, eTaken);
                checkOutput("m0_target", bus0.pred_target, eTgt);
                checkOutput("m0_ghr", bus0.pred_ghr, mGhr[0]);
                checkOutput("m0_perf_lookups", bus0.perf_lookups, ePerf[0]);
                checkOutput("m0_perf_branches", bus0.perf_branches, ePerf[1]);
                checkOutput("m0_perf_mispredicts", bus0.perf_mispredicts, ePerf[2]);
            end else begin
                checkOutput("m1_hit", bus1.pred_hit, eHit);
                checkOutput("m1_taken", bus1.pred_taken, eTaken);
                checkOutput("m1_target", bus1.pred_target, eTgt);
                checkOutput("m1_ghr", bus1.pred_ghr, mGhr[1]);
                checkOutput("m1_perf_lookups", bus1.perf_lookups, ePerf[0]);
                checkOutput("m1_perf_branches", bus1.perf_branches, ePerf[1]);
                checkOutput("m1_perf_mispredicts", bus1.perf_mispredicts, ePerf[2]);
            end
        end
    endtask

    // Drive the current stimulus and compare outputs before the coming edge.
    task automatic applyStimulus();
        driveBus();
        #1;
        compareAll();
    endtask

    // Advance the model and the DUTs by one edge, ending on the falling edge.
    task automatic endCycle();
        mdlClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset();
        setIdle();
        driveBus();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdlReset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // ce, lkV, lkPc, uV, uPc, uTaken, uTgt, uMis, expHit, expTaken, expTgt (bimodal)
        vecs[0]  = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20};
        vecs[3]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20};
        vecs[4]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20};
        vecs[5]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20};
        vecs[6]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20};
        vecs[7]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h20};
        vecs[8]  = '{1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20};
        vecs[9]  = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h20};
        vecs[10] = '{1'b1, 1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 32'h140, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h80};
        vecs[14] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};

        applyReset();

        // Reset state with a lookup in flight.
        sLkValid = 1'b1; sLkPc = 32'h40;
        applyStimulus();
        checkOutput("reset_hit", bus0.pred_hit, 1'b0);
        checkOutput("reset_taken", bus0.pred_taken, 1'b0);
        checkOutput("reset_target", bus0.pred_target, 32'h0);
        checkOutput("reset_ghr", bus1.pred_ghr, 6'd0);
        endCycle();

        // Directed bimodal sequence: allocate, saturate, decay, same-cycle, alias.
        for (int v = 0; v < 16; v++) begin
            setIdle();
            sCe = vecs[v].ce; sLkValid = vecs[v].lkValid; sLkPc = vecs[v].lkPc;
            sUpdValid = vecs[v].updValid; sUpdPc = vecs[v].updPc;
            sUpdTaken = vecs[v].updTaken; sUpdTarget = vecs[v].updTarget;
            sUpdMis = vecs[v].updMis;
            applyStimulus();
            checkOutput($sformatf("vec%0d_hit", v), bus0.pred_hit, vecs[v].expHit);
            checkOutput($sformatf("vec%0d_taken", v), bus0.pred_taken, vecs[v].expTaken);
            checkOutput($sformatf("vec%0d_target", v), bus0.pred_target, vecs[v].expTarget);
            endCycle();
        end

        // Reset asserted while an allocating update is being presented.
        setIdle();
        sLkValid = 1'b1; sLkPc = 32'h40;
        sUpdValid = 1'b1; sUpdPc = 32'h40; sUpdTaken = 1'b1; sUpdTarget = 32'h24;
        applyStimulus();
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdlReset();
        setIdle();
        sLkValid = 1'b1; sLkPc = 32'h40;
        applyStimulus();
        checkOutput("rst_mid_m0_hit", bus0.pred_hit, 1'b0);
        checkOutput("rst_mid_m1_hit", bus1.pred_hit, 1'b0);
        checkOutput("rst_mid_m1_ghr", bus1.pred_ghr, 6'd0);
        endCycle();
        setIdle();
        sLkValid = 1'b1; sLkPc = 32'h140;
        applyStimulus();
        checkOutput("rst_mid_alias_hit", bus0.pred_hit, 1'b0);
        endCycle();

        // Gshare: allocate at index pcidx^110000, then repair history to 110000.
        setIdle();
        sUpdValid = 1'b1; sUpdPc = 32'h1000; sUpdGhr = 6'b110000;
        sUpdTaken = 1'b1; sUpdTarget = 32'h44;
        applyStimulus();
        endCycle();
        setIdle();
        sUpdValid = 1'b1; sUpdPc = 32'h2000; sUpdGhr = 6'b011000; sUpdMis = 1'b1;
        applyStimulus();
        endCycle();
        checkOutput("gshare_ghr_setup", bus1.pred_ghr, 6'b110000);

        // Hit lookup plus same-cycle mispredict repair, first with ce low.
        for (int pass = 0; pass < 2; pass++) begin
            int unsigned baseMis;
            setIdle();
            sCe = (pass == 1);
            sLkValid = 1'b1; sLkPc = 32'h1000;
            sUpdValid = 1'b1; sUpdPc = 32'h3000; sUpdGhr = 6'b000101;
            sUpdTaken = 1'b1; sUpdTarget = 32'h10; sUpdMis = 1'b1;
            applyStimulus();
            checkOutput($sformatf("gshare_pass%0d_hit", pass), bus1.pred_hit, 1'b1);
            checkOutput($sformatf("gshare_pass%0d_target", pass), bus1.pred_target, 32'h44);
            baseMis = mPerf[2];
            endCycle();
            if (pass == 0) begin
                checkOutput("gshare_ce0_ghr", bus1.pred_ghr, 6'b110000);
            end else begin
                checkOutput("gshare_repair_ghr", bus1.pred_ghr, 6'b001011);
            end
`ifdef BRANCH_PREDICTOR_PERF_EN
            checkOutput($sformatf("gshare_pass%0d_perf_mis", pass), bus1.perf_mispredicts,
                        baseMis + ((pass == 1) ? 32'd1 : 32'd0));
`else
            checkOutput($sformatf("gshare_pass%0d_perf_mis", pass), bus1.perf_mispredicts,
                        32'd0 + (baseMis & 32'd0));
`endif
        end

        // Random traffic over a small pc pool so entries hit, alias and saturate.
        for (int n = 0; n < 500; n++) begin
            setIdle();
            sCe        = ($urandom_range(0, 9) != 0);
            sLkValid   = ($urandom_range(0, 3) != 0);
            sLkPc      = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            sUpdValid  = ($urandom_range(0, 1) != 0);
            sUpdPc     = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            sUpdGhr    = ($urandom_range(0, 1) != 0) ? 6'(mGhr[1]) : 6'($urandom_range(0, 63));
            sUpdTaken  = ($urandom_range(0, 2) != 0);
            sUpdTarget = $urandom() & 32'hFFFF_FFFC;
            sUpdMis    = ($urandom_range(0, 3) == 0);
            applyStimulus();
            endCycle();
        end

        setIdle();
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
